// File: rtl/mmio_timer_responder.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT register window on the M-stage data bus,
// with an interrupt request line for CP0. Supports one-shot (MODE 00/10/11) and auto-reload (MODE 01).
module mmio_timer_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int          WIDTH     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CNT  = 2'd2;
  localparam logic [1:0] INT  = 2'd3;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  logic [3:0]       ctrl;
  logic [WIDTH-1:0] preset;
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             irq_flag;

  logic             ctrl_en;
  logic [1:0]       ctrl_mode;
  logic             ctrl_im;
  logic             hit;
  logic             any_write;
  logic             ctrl_write;
  logic             ctrl_byte_write;
  logic             preset_write;
  logic             count_zero;
  logic             fsm_clears_en;
  logic [31:0]      byte_mask;
  logic [31:0]      preset_merged;

  assign ctrl_en   = ctrl[0];
  assign ctrl_mode = ctrl[2:1];
  assign ctrl_im   = ctrl[3];

  // The window is four words wide but only offsets 0..2 decode; offset 3 behaves like a miss.
  assign hit             = (addr[29:2] == BASE_ADDR[31:4]) && (addr[1:0] <= OFF_COUNT);
  assign any_write       = hit && (byteen != 4'b0000);
  assign ctrl_write      = any_write && (addr[1:0] == OFF_CTRL);
  assign ctrl_byte_write = ctrl_write && byteen[0];
  assign preset_write    = any_write && (addr[1:0] == OFF_PRESET);

  assign count_zero    = (count == '0);
  assign fsm_clears_en = (state == INT) && (ctrl_mode != MODE_RELOAD);

  assign byte_mask     = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
  assign preset_merged = (32'(preset) & ~byte_mask) | (wdata & byte_mask);

  always_comb begin
    rdata = 32'h0000_0000;
    if (hit) begin
      case (addr[1:0])
        OFF_CTRL:   rdata = {28'h000_0000, ctrl};
        OFF_PRESET: rdata = 32'(preset);
        OFF_COUNT:  rdata = 32'(count);
        default:    rdata = 32'h0000_0000;
      endcase
    end
  end

  assign irq = ctrl_im & irq_flag;

  // A CPU write to byte 0 of CTRL overrides the one-shot EN clear landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= 4'b0000;
    end else if (ctrl_byte_write) begin
      ctrl <= wdata[3:0];
    end else if (fsm_clears_en) begin
      ctrl[0] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      preset <= '0;
    end else if (preset_write) begin
      preset <= WIDTH'(preset_merged);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl_en) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl_en) begin
            state <= IDLE;
          end else if (count_zero) begin
            state <= INT;
          end else begin
            count <= count - WIDTH'(1);
          end
        end
        INT: begin
          if (ctrl_mode == MODE_RELOAD) begin
            state <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Software clear has priority over the hardware set when both land on one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_flag <= 1'b0;
    end else if (ctrl_write || preset_write) begin
      irq_flag <= 1'b0;
    end else if ((state == CNT) && ctrl_en && count_zero) begin
      irq_flag <= 1'b1;
    end else if ((state == INT) && (ctrl_mode == MODE_RELOAD)) begin
      irq_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Self-checking bench for mmio_timer_responder: per-edge COUNT/irq expectations are queued
// before each run and popped as every clock edge produces the next DUT state.
module tb_mmio_timer_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  localparam logic [29:0] W_CTRL   = 30'h0000_1FC0;
  localparam logic [29:0] W_PRESET = 30'h0000_1FC1;
  localparam logic [29:0] W_COUNT  = 30'h0000_1FC2;
  localparam logic [29:0] W_GAP    = 30'h0000_1FC3;
  localparam logic [29:0] W_MISS   = 30'h0000_1FC4;

  typedef struct {
    string       tag;
    logic [31:0] cnt;
    logic        irq;
  } step_t;

  step_t sb[$];
  int    n_checks = 0;
  int    n_fails  = 0;

  mmio_timer_responder #(
    .BASE_ADDR(32'h0000_7F00),
    .WIDTH    (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .byteen(byteen),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic sb_push(input string tag, input logic [31:0] cnt, input logic irq_e);
    step_t s;
    s.tag = tag;
    s.cnt = cnt;
    s.irq = irq_e;
    sb.push_back(s);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [29:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    addr   = a;
    byteen = be;
    wdata  = d;
    @(posedge clk);
    #1;
    byteen = 4'b0000;
    wdata  = 32'h0;
  endtask

  task automatic read_reg(input logic [29:0] a, output logic [31:0] v);
    addr   = a;
    byteen = 4'b0000;
    #1;
    v = rdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    byteen = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    do_write(W_PRESET, 4'b1111, 32'h0000_1234);
    do_write(W_CTRL, 4'b0001, 32'h0000_0009);
    repeat (3) tick();
    do_reset();
    read_reg(W_CTRL, v);
    n_checks++;
    if (v !== 32'h0) begin n_fails++; $display("[TB] FAIL reset_ctrl: got %h expected %h", v, 32'h0); end
    read_reg(W_PRESET, v);
    n_checks++;
    if (v !== 32'h0) begin n_fails++; $display("[TB] FAIL reset_preset: got %h expected %h", v, 32'h0); end
    read_reg(W_COUNT, v);
    n_checks++;
    if (v !== 32'h0) begin n_fails++; $display("[TB] FAIL reset_count: got %h expected %h", v, 32'h0); end
    n_checks++;
    if (irq !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_mode0();
    logic [31:0] v;
    step_t       s;
    do_reset();
    do_write(W_PRESET, 4'b1111, 32'd3);
    for (int k = 1; k <= 9; k++)
      sb_push($sformatf("mode0_e%0d", k), (k >= 2 && k <= 5) ? 32'(5 - k) : 32'd0, k >= 6);
    do_write(W_CTRL, 4'b0001, 32'h0000_0009);
    for (int k = 1; k <= 9; k++) begin
      tick();
      read_reg(W_COUNT, v);
      if (sb.size() == 0) begin
        n_checks++; n_fails++;
        $display("[TB] FAIL mode0_queue: got empty expected entry");
      end else begin
        s = sb.pop_front();
        n_checks++;
        if (v !== s.cnt) begin n_fails++; $display("[TB] FAIL %s_count: got %h expected %h", s.tag, v, s.cnt); end
        n_checks++;
        if (irq !== s.irq) begin n_fails++; $display("[TB] FAIL %s_irq: got %b expected %b", s.tag, irq, s.irq); end
      end
    end
    read_reg(W_CTRL, v);
    n_checks++;
    if (v !== 32'h8) begin n_fails++; $display("[TB] FAIL mode0_ctrl_en_cleared: got %h expected %h", v, 32'h8); end
    do_write(W_CTRL, 4'b0001, 32'h0);
    n_checks++;
    if (irq !== 1'b0) begin n_fails++; $display("[TB] FAIL mode0_irq_cleared: got %b expected 0", irq); end
  endtask

  task automatic test_mode1();
    logic [31:0] v;
    step_t       s;
    int          p;
    do_reset();
    do_write(W_PRESET, 4'b1111, 32'd2);
    for (int k = 1; k <= 16; k++) begin
      p = (k - 1) % 5;
      sb_push($sformatf("mode1_e%0d", k), (p == 1) ? 32'd2 : ((p == 2) ? 32'd1 : 32'd0), p == 4);
    end
    do_write(W_CTRL, 4'b0001, 32'h0000_000B);
    for (int k = 1; k <= 16; k++) begin
      tick();
      read_reg(W_COUNT, v);
      if (sb.size() == 0) begin
        n_checks++; n_fails++;
        $display("[TB] FAIL mode1_queue: got empty expected entry");
      end else begin
        s = sb.pop_front();
        n_checks++;
        if (v !== s.cnt) begin n_fails++; $display("[TB] FAIL %s_count: got %h expected %h", s.tag, v, s.cnt); end
        n_checks++;
        if (irq !== s.irq) begin n_fails++; $display("[TB] FAIL %s_irq: got %b expected %b", s.tag, irq, s.irq); end
      end
    end
    read_reg(W_CTRL, v);
    n_checks++;
    if (v !== 32'hB) begin n_fails++; $display("[TB] FAIL mode1_ctrl_kept: got %h expected %h", v, 32'hB); end
  endtask

  task automatic test_byteen_mask();
    logic [31:0] v;
    step_t       s;
    do_reset();
    do_write(W_PRESET, 4'b0011, 32'hAABB_CCDD);
    read_reg(W_PRESET, v);
    n_checks++;
    if (v !== 32'h0000_CCDD) begin n_fails++; $display("[TB] FAIL preset_low_bytes: got %h expected %h", v, 32'h0000_CCDD); end
    do_write(W_PRESET, 4'b1100, 32'h1122_3344);
    read_reg(W_PRESET, v);
    n_checks++;
    if (v !== 32'h1122_CCDD) begin n_fails++; $display("[TB] FAIL preset_high_bytes: got %h expected %h", v, 32'h1122_CCDD); end
    do_write(W_COUNT, 4'b1111, 32'hFFFF_FFFF);
    read_reg(W_COUNT, v);
    n_checks++;
    if (v !== 32'h0) begin n_fails++; $display("[TB] FAIL count_write_dropped: got %h expected %h", v, 32'h0); end
    do_write(W_CTRL, 4'b1110, 32'hFFFF_FFFF);
    do_write(W_GAP, 4'b1111, 32'h0000_0009);
    do_write(W_MISS, 4'b1111, 32'h0000_0009);
    read_reg(W_CTRL, v);
    n_checks++;
    if (v !== 32'h0) begin n_fails++; $display("[TB] FAIL ctrl_untouched: got %h expected %h", v, 32'h0); end
    do_write(W_MISS + 30'd1, 4'b1111, 32'h5555_5555);
    read_reg(W_PRESET, v);
    n_checks++;
    if (v !== 32'h1122_CCDD) begin n_fails++; $display("[TB] FAIL preset_miss_ignored: got %h expected %h", v, 32'h1122_CCDD); end
    read_reg(W_GAP, v);
    n_checks++;
    if (v !== 32'h0) begin n_fails++; $display("[TB] FAIL gap_reads_zero: got %h expected %h", v, 32'h0); end
    read_reg(W_MISS, v);
    n_checks++;
    if (v !== 32'h0) begin n_fails++; $display("[TB] FAIL miss_reads_zero: got %h expected %h", v, 32'h0); end

    do_write(W_PRESET, 4'b1111, 32'd2);
    for (int k = 1; k <= 7; k++)
      sb_push($sformatf("masked_e%0d", k), (k == 2) ? 32'd2 : ((k == 3) ? 32'd1 : 32'd0), 1'b0);
    for (int k = 1; k <= 6; k++)
      sb_push($sformatf("unmasked_e%0d", k), (k == 2) ? 32'd2 : ((k == 3) ? 32'd1 : 32'd0), k >= 5);
    do_write(W_CTRL, 4'b0001, 32'h0000_0001);
    for (int k = 1; k <= 7; k++) begin
      tick();
      read_reg(W_COUNT, v);
      if (sb.size() == 0) begin
        n_checks++; n_fails++;
        $display("[TB] FAIL masked_queue: got empty expected entry");
      end else begin
        s = sb.pop_front();
        n_checks++;
        if (v !== s.cnt) begin n_fails++; $display("[TB] FAIL %s_count: got %h expected %h", s.tag, v, s.cnt); end
        n_checks++;
        if (irq !== s.irq) begin n_fails++; $display("[TB] FAIL %s_irq: got %b expected %b", s.tag, irq, s.irq); end
      end
    end
    read_reg(W_CTRL, v);
    n_checks++;
    if (v !== 32'h0) begin n_fails++; $display("[TB] FAIL masked_ctrl: got %h expected %h", v, 32'h0); end
    do_write(W_CTRL, 4'b0001, 32'h0000_0009);
    for (int k = 1; k <= 6; k++) begin
      tick();
      read_reg(W_COUNT, v);
      if (sb.size() == 0) begin
        n_checks++; n_fails++;
        $display("[TB] FAIL unmasked_queue: got empty expected entry");
      end else begin
        s = sb.pop_front();
        n_checks++;
        if (v !== s.cnt) begin n_fails++; $display("[TB] FAIL %s_count: got %h expected %h", s.tag, v, s.cnt); end
        n_checks++;
        if (irq !== s.irq) begin n_fails++; $display("[TB] FAIL %s_irq: got %b expected %b", s.tag, irq, s.irq); end
      end
    end
  endtask

  task automatic test_pause_edge();
    logic [31:0] v;
    step_t       s;
    do_reset();
    do_write(W_PRESET, 4'b1111, 32'd8);
    sb_push("pause_e1", 32'd0, 1'b0);
    sb_push("pause_e2", 32'd8, 1'b0);
    sb_push("pause_e3", 32'd7, 1'b0);
    sb_push("pause_e4", 32'd6, 1'b0);
    do_write(W_CTRL, 4'b0001, 32'h0000_0009);
    for (int k = 1; k <= 4; k++) begin
      tick();
      read_reg(W_COUNT, v);
      if (sb.size() == 0) begin
        n_checks++; n_fails++;
        $display("[TB] FAIL pause_queue: got empty expected entry");
      end else begin
        s = sb.pop_front();
        n_checks++;
        if (v !== s.cnt) begin n_fails++; $display("[TB] FAIL %s_count: got %h expected %h", s.tag, v, s.cnt); end
        n_checks++;
        if (irq !== s.irq) begin n_fails++; $display("[TB] FAIL %s_irq: got %b expected %b", s.tag, irq, s.irq); end
      end
    end
    do_write(W_CTRL, 4'b0001, 32'h0000_0008);
    for (int k = 1; k <= 3; k++) sb_push($sformatf("frozen_e%0d", k), 32'd5, 1'b0);
    sb_push("p0_e1", 32'd5, 1'b0);
    sb_push("p0_e2", 32'd0, 1'b0);
    sb_push("p0_e3", 32'd0, 1'b1);
    sb_push("p0_e4", 32'd0, 1'b1);
    sb_push("p0_e5", 32'd0, 1'b1);
    read_reg(W_COUNT, v);
    n_checks++;
    if (v !== 32'd5) begin n_fails++; $display("[TB] FAIL pause_count: got %h expected %h", v, 32'd5); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      read_reg(W_COUNT, v);
      if (sb.size() == 0) begin
        n_checks++; n_fails++;
        $display("[TB] FAIL frozen_queue: got empty expected entry");
      end else begin
        s = sb.pop_front();
        n_checks++;
        if (v !== s.cnt) begin n_fails++; $display("[TB] FAIL %s_count: got %h expected %h", s.tag, v, s.cnt); end
        n_checks++;
        if (irq !== s.irq) begin n_fails++; $display("[TB] FAIL %s_irq: got %b expected %b", s.tag, irq, s.irq); end
      end
    end
    read_reg(W_CTRL, v);
    n_checks++;
    if (v !== 32'h8) begin n_fails++; $display("[TB] FAIL pause_ctrl: got %h expected %h", v, 32'h8); end

    do_write(W_PRESET, 4'b1111, 32'd0);
    do_write(W_CTRL, 4'b0001, 32'h0000_0009);
    for (int k = 1; k <= 5; k++) begin
      tick();
      read_reg(W_COUNT, v);
      if (sb.size() == 0) begin
        n_checks++; n_fails++;
        $display("[TB] FAIL p0_queue: got empty expected entry");
      end else begin
        s = sb.pop_front();
        n_checks++;
        if (v !== s.cnt) begin n_fails++; $display("[TB] FAIL %s_count: got %h expected %h", s.tag, v, s.cnt); end
        n_checks++;
        if (irq !== s.irq) begin n_fails++; $display("[TB] FAIL %s_irq: got %b expected %b", s.tag, irq, s.irq); end
      end
    end

    do_write(W_PRESET, 4'b1111, 32'd10);
    do_write(W_CTRL, 4'b0001, 32'h0000_0009);
    repeat (3) tick();
    read_reg(W_COUNT, v);
    n_checks++;
    if (v !== 32'd9) begin n_fails++; $display("[TB] FAIL midcount_before_reset: got %h expected %h", v, 32'd9); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    read_reg(W_CTRL, v);
    n_checks++;
    if (v !== 32'h0) begin n_fails++; $display("[TB] FAIL midreset_ctrl: got %h expected %h", v, 32'h0); end
    read_reg(W_PRESET, v);
    n_checks++;
    if (v !== 32'h0) begin n_fails++; $display("[TB] FAIL midreset_preset: got %h expected %h", v, 32'h0); end
    read_reg(W_COUNT, v);
    n_checks++;
    if (v !== 32'h0) begin n_fails++; $display("[TB] FAIL midreset_count: got %h expected %h", v, 32'h0); end
    n_checks++;
    if (irq !== 1'b0) begin n_fails++; $display("[TB] FAIL midreset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    step_t       s;
    do_reset();
    do_write(W_PRESET, 4'b1111, 32'd1);
    sb_push("clr_e1", 32'd0, 1'b0);
    sb_push("clr_e2", 32'd1, 1'b0);
    sb_push("clr_e3", 32'd0, 1'b0);
    do_write(W_CTRL, 4'b0001, 32'h0000_0009);
    for (int k = 1; k <= 3; k++) begin
      tick();
      read_reg(W_COUNT, v);
      if (sb.size() == 0) begin
        n_checks++; n_fails++;
        $display("[TB] FAIL clr_queue: got empty expected entry");
      end else begin
        s = sb.pop_front();
        n_checks++;
        if (v !== s.cnt) begin n_fails++; $display("[TB] FAIL %s_count: got %h expected %h", s.tag, v, s.cnt); end
        n_checks++;
        if (irq !== s.irq) begin n_fails++; $display("[TB] FAIL %s_irq: got %b expected %b", s.tag, irq, s.irq); end
      end
    end
    do_write(W_PRESET, 4'b1111, 32'd1);
    n_checks++;
    if (irq !== 1'b0) begin n_fails++; $display("[TB] FAIL clear_beats_set: got %b expected 0", irq); end
    tick();
    n_checks++;
    if (irq !== 1'b0) begin n_fails++; $display("[TB] FAIL clear_beats_set_held: got %b expected 0", irq); end
    read_reg(W_CTRL, v);
    n_checks++;
    if (v !== 32'h8) begin n_fails++; $display("[TB] FAIL clear_ctrl_idle: got %h expected %h", v, 32'h8); end

    sb_push("rw_e1", 32'd0, 1'b0);
    sb_push("rw_e2", 32'd1, 1'b0);
    sb_push("rw_e3", 32'd0, 1'b0);
    sb_push("rw_e4", 32'd0, 1'b1);
    do_write(W_CTRL, 4'b0001, 32'h0000_0009);
    for (int k = 1; k <= 4; k++) begin
      tick();
      read_reg(W_COUNT, v);
      if (sb.size() == 0) begin
        n_checks++; n_fails++;
        $display("[TB] FAIL rw_queue: got empty expected entry");
      end else begin
        s = sb.pop_front();
        n_checks++;
        if (v !== s.cnt) begin n_fails++; $display("[TB] FAIL %s_count: got %h expected %h", s.tag, v, s.cnt); end
        n_checks++;
        if (irq !== s.irq) begin n_fails++; $display("[TB] FAIL %s_irq: got %b expected %b", s.tag, irq, s.irq); end
      end
    end
    sb_push("restart_e6", 32'd0, 1'b0);
    sb_push("restart_e7", 32'd1, 1'b0);
    do_write(W_CTRL, 4'b0001, 32'h0000_0009);
    n_checks++;
    if (irq !== 1'b0) begin n_fails++; $display("[TB] FAIL cpu_write_in_int_irq: got %b expected 0", irq); end
    read_reg(W_CTRL, v);
    n_checks++;
    if (v !== 32'h9) begin n_fails++; $display("[TB] FAIL cpu_write_wins_ctrl: got %h expected %h", v, 32'h9); end
    for (int k = 1; k <= 2; k++) begin
      tick();
      read_reg(W_COUNT, v);
      if (sb.size() == 0) begin
        n_checks++; n_fails++;
        $display("[TB] FAIL restart_queue: got empty expected entry");
      end else begin
        s = sb.pop_front();
        n_checks++;
        if (v !== s.cnt) begin n_fails++; $display("[TB] FAIL %s_count: got %h expected %h", s.tag, v, s.cnt); end
        n_checks++;
        if (irq !== s.irq) begin n_fails++; $display("[TB] FAIL %s_irq: got %b expected %b", s.tag, irq, s.irq); end
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    addr   = W_CTRL;
    byteen = 4'b0000;
    wdata  = 32'h0;
    test_reset();
    test_mode0();
    test_mode1();
    test_byteen_mask();
    test_pause_edge();
    test_back_to_back();
    n_checks++;
    if (sb.size() != 0) begin
      n_fails++;
      $display("[TB] FAIL scoreboard_drained: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
